// File: rtl/prog_mem.sv
// Program memory with a streaming loader and a single-cycle fetch port.
// A load fills words from address 0 upward. Fetches outside the loaded program return NOP_WORD with an error flag.
module prog_mem #(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 4,
    parameter int unsigned          DEPTH    = 16,
    parameter logic [DATA_W-1:0]    NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_instr,
    output logic              rd_err,
    output logic [ADDR_W:0]   prog_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] mem_q;
    logic [ADDR_W-1:0] wptr;
    logic              accept;
    logic              last_word;
    logic              rd_ok;

    // Restart and reset both take priority over a word on the loader bus.
    assign accept    = (state == LOAD) && ld_valid && !ld_start && !rst;
    assign last_word = ld_last || (wptr == ADDR_W'(DEPTH - 1));
    assign rd_ok     = rd_req && (state == RUN) && !ld_start
                       && ({1'b0, rd_addr} < prog_len);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ld_start) state_nxt = LOAD;
            LOAD: begin
                if (ld_start)
                    state_nxt = LOAD;
                else if (accept && last_word)
                    state_nxt = RUN;
            end
            RUN:  if (ld_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = (state == LOAD);
        rd_instr = (rd_valid && !rd_err) ? mem_q : NOP_WORD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            prog_len <= '0;
            ld_done  <= 1'b0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            ld_done  <= accept && last_word;
            rd_valid <= rd_req;
            rd_err   <= rd_req && !rd_ok;
            if (ld_start) begin
                wptr     <= '0;
                prog_len <= '0;
            end else if (accept) begin
                // Hold at the top word so the pointer never wraps.
                if (!last_word)
                    wptr <= wptr + ADDR_W'(1);
                prog_len <= prog_len + (ADDR_W + 1)'(1);
            end
        end
    end

    // Storage is not reset; prog_len gates visibility of stale words.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= ld_data;
        if (rd_ok)
            mem_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: table-driven fetch vectors plus hand-written load, restart and reset sequences.
module tb_prog_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_start, ld_valid, ld_last, ld_ready, ld_done;
    logic [7:0] ld_data;
    logic       rd_req, rd_valid, rd_err;
    logic [3:0] rd_addr;
    logic [7:0] rd_instr;
    logic [4:0] prog_len;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] instr;
        logic       err;
    } fvec_t;

    fvec_t fv [8];

    prog_mem #(
        .DATA_W   (8),
        .ADDR_W   (4),
        .DEPTH    (16),
        .NOP_WORD (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_instr (rd_instr),
        .rd_err   (rd_err),
        .prog_len (prog_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [3:0] a,
                         input logic [7:0] exp_i, input logic exp_e);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        check({name, " valid"}, rd_valid, 1);
        check({name, " instr"}, rd_instr, exp_i);
        check({name, " err"},   rd_err,   exp_e);
    endtask

    initial begin
        fv[0] = '{4'd0,  8'h13, 1'b0};
        fv[1] = '{4'd1,  8'h25, 1'b0};
        fv[2] = '{4'd2,  8'h40, 1'b0};
        fv[3] = '{4'd3,  8'h80, 1'b0};
        fv[4] = '{4'd5,  8'h00, 1'b1};
        fv[5] = '{4'd4,  8'h00, 1'b1};
        fv[6] = '{4'd15, 8'h00, 1'b1};
        fv[7] = '{4'd2,  8'h40, 1'b0};

        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst ld_ready", ld_ready, 0);
        check("rst ld_done",  ld_done,  0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_err",   rd_err,   0);
        check("rst rd_instr", rd_instr, 8'h00);
        check("rst prog_len", prog_len, 0);

        fetch("idle fetch", 4'd0, 8'h00, 1'b1);
        tick();
        check("idle after valid", rd_valid, 0);
        check("idle after err",   rd_err,   0);

        // Basic load of four words
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        check("load ready",   ld_ready, 1);
        check("load len0",    prog_len, 0);
        load_word(8'h13, 1'b0);
        load_word(8'h25, 1'b0);
        load_word(8'h40, 1'b0);
        check("load no done", ld_done, 0);
        check("load len3",    prog_len, 3);
        load_word(8'h80, 1'b1);
        check("load done",    ld_done,  1);
        check("load len4",    prog_len, 4);
        check("load ready0",  ld_ready, 0);
        tick();
        check("done pulse",   ld_done,  0);

        // Back-to-back fetch table
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = fv[i].addr;
            tick();
            check($sformatf("vec%0d valid", i), rd_valid, 1);
            check($sformatf("vec%0d instr", i), rd_instr, fv[i].instr);
            check($sformatf("vec%0d err", i),   rd_err,   fv[i].err);
        end
        rd_req = 1'b0;
        tick();
        check("b2b idle valid", rd_valid, 0);
        check("b2b idle instr", rd_instr, 8'h00);

        // Fetch and ld_start together in RUN
        rd_req = 1'b1; rd_addr = 4'd0; ld_start = 1'b1;
        tick();
        rd_req = 1'b0; ld_start = 1'b0;
        check("prio valid", rd_valid, 1);
        check("prio err",   rd_err,   1);
        check("prio instr", rd_instr, 8'h00);
        check("prio ready", ld_ready, 1);
        check("prio len",   prog_len, 0);

        // Full-depth load without ld_last
        for (int i = 0; i < 16; i++) begin
            load_word(8'hA0 + 8'(i), 1'b0);
            if (i == 14) begin
                check("full no done", ld_done,  0);
                check("full ready15", ld_ready, 1);
            end
        end
        check("full done",  ld_done,  1);
        check("full len",   prog_len, 16);
        check("full ready", ld_ready, 0);
        load_word(8'hFF, 1'b0);
        check("full 17 len",  prog_len, 16);
        check("full 17 done", ld_done,  0);
        fetch("full top", 4'd15, 8'hAF, 1'b0);
        fetch("full bot", 4'd0,  8'hA0, 1'b0);

        // Restart mid-load
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        load_word(8'h11, 1'b0);
        load_word(8'h22, 1'b0);
        check("rs len2", prog_len, 2);
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        check("rs len0",  prog_len, 0);
        check("rs ready", ld_ready, 1);
        check("rs done",  ld_done,  0);
        fetch("load fetch", 4'd0, 8'h00, 1'b1);
        load_word(8'h31, 1'b0);
        load_word(8'h32, 1'b1);
        check("rs2 done", ld_done,  1);
        check("rs2 len",  prog_len, 2);
        fetch("rs2 f0", 4'd0, 8'h31, 1'b0);
        fetch("rs2 f2", 4'd2, 8'h00, 1'b1);

        // Reset mid-load with a coincident word and fetch
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        load_word(8'h55, 1'b0);
        check("rl len1", prog_len, 1);
        rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h66; rd_req = 1'b1; rd_addr = 4'd0;
        tick();
        rst = 1'b0; ld_valid = 1'b0; rd_req = 1'b0;
        check("rl ready", ld_ready, 0);
        check("rl len",   prog_len, 0);
        check("rl valid", rd_valid, 0);
        check("rl done",  ld_done,  0);
        fetch("rl fetch", 4'd0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
